pma_region_unit: RTL and testbench

- Runtime-programmable physical memory attribute (PMA) table; successor to the static per-core region rules (non-idempotent, execute, cached).
- Holds NrRegions programmable entries. Each entry has a base, a length and attribute bits.
- Answers address lookups through a 1-cycle pipelined valid/ready port.
- Sits beside the CSR file (config port) and serves the fetch/LSU PMA check (lookup port). Reset contents come from parameters, so the static configuration is a special case.

---
 rtl/pma_pkg.sv | 49 ++++
 rtl/pma_prio_enc.sv | 23 ++
 rtl/pma_region_unit.sv | 153 +++++++++++++++
 tb/tb_pma_region_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pma_pkg.sv
// PMA table shared types: attribute byte, table entry, field selects
// and the region match helper used by the lookup path.
package pma_pkg;

    localparam int unsigned PmaAw = 64;

    typedef logic [PmaAw-1:0] pma_addr_t;

    // Packed MSB first: bit7 lock ... bit0 en.
    typedef struct packed {
        logic       lock;
        logic [2:0] rsvd;
        logic       cached;
        logic       exec;
        logic       nonidem;
        logic       en;
    } pma_attr_t;

    typedef struct packed {
        pma_addr_t base;
        pma_addr_t length;
        pma_attr_t attr;
    } pma_entry_t;

    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_LEN  = 2'd1;
    localparam logic [1:0] SEL_ATTR = 2'd2;

    // Reserved attribute bits are never stored.
    function automatic pma_attr_t pma_attr_clean(input logic [7:0] b);
        pma_attr_t a;
        a      = pma_attr_t'(b);
        a.rsvd = 3'b000;
        return a;
    endfunction

    // Limit is computed one bit wider so a region ending exactly at
    // the top of the address space still matches its last byte.
    function automatic logic pma_match(input pma_entry_t e,
                                       input pma_addr_t  addr);
        logic [PmaAw:0] lim;
        lim = {1'b0, e.base} + {1'b0, e.length};
        return e.attr.en
            && (e.length != '0)
            && (addr >= e.base)
            && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/pma_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports: req_i (one bit per region), hit_o (any set), idx_o (lowest set).
module pma_prio_enc #(
    parameter int unsigned N        = 8,
    parameter int unsigned IdxWidth = 4
) (
    input  logic [N-1:0]        req_i,
    output logic                hit_o,
    output logic [IdxWidth-1:0] idx_o
);

    always_comb begin
        hit_o = |req_i;
        idx_o = '0;
        // Descending scan: the last assignment is the lowest index.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/pma_region_unit.sv
// Runtime-programmable PMA table with config port and 1-cycle lookup.
// Ports: clk_i/rst_ni, cfg_* (CSR-side read/write), req_*/resp_* (lookup).
module pma_region_unit
    import pma_pkg::*;
#(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 64,
    parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase = '0,
    parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLength = '0,
    parameter pma_attr_t [NrRegions-1:0] RstAttr = '0,
    parameter pma_attr_t DefaultAttr = pma_attr_t'(0)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic                 cfg_re_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_sel_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_hit_o,
    output logic [3:0]           resp_idx_o,
    output logic [7:0]           resp_attr_o
);

    pma_entry_t entries [NrRegions];

    pma_entry_t           sel_entry;
    logic                 idx_ok;
    logic                 sel_ok;
    logic                 wr_err;
    logic                 rd_err;
    logic [AddrWidth-1:0] rd_field;

    logic [NrRegions-1:0] match;
    logic                 enc_hit;
    logic [3:0]           enc_idx;
    pma_attr_t            look_attr;
    pma_attr_t            resp_attr_q;

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < int'(NrRegions); i++) begin
            if (cfg_idx_i == 4'(i)) begin
                sel_entry = entries[i];
            end
        end
    end

    assign idx_ok = {1'b0, cfg_idx_i} < 5'(NrRegions);
    assign sel_ok = cfg_sel_i != 2'd3;
    assign rd_err = !idx_ok || !sel_ok;
    assign wr_err = rd_err || sel_entry.attr.lock;

    always_comb begin
        case (cfg_sel_i)
            SEL_BASE: rd_field = AddrWidth'(sel_entry.base);
            SEL_LEN:  rd_field = AddrWidth'(sel_entry.length);
            SEL_ATTR: rd_field = AddrWidth'(sel_entry.attr);
            default:  rd_field = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                entries[i].base   <= pma_addr_t'(RstBase[i]);
                entries[i].length <= pma_addr_t'(RstLength[i]);
                entries[i].attr   <= pma_attr_clean(RstAttr[i]);
            end
        end else if (cfg_we_i && !wr_err) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                if (cfg_idx_i == 4'(i)) begin
                    case (cfg_sel_i)
                        SEL_BASE: entries[i].base <= pma_addr_t'(cfg_wdata_i);
                        SEL_LEN:  entries[i].length <= pma_addr_t'(cfg_wdata_i);
                        SEL_ATTR: entries[i].attr <= pma_attr_clean(cfg_wdata_i[7:0]);
                        default:  ;
                    endcase
                end
            end
        end
    end

    // A write takes priority; a concurrent read leaves rdata untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_rdata_o <= '0;
            cfg_err_o   <= 1'b0;
        end else begin
            cfg_err_o <= 1'b0;
            if (cfg_we_i) begin
                cfg_err_o <= wr_err;
            end else if (cfg_re_i) begin
                cfg_err_o   <= rd_err;
                cfg_rdata_o <= rd_err ? '0 : rd_field;
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < int'(NrRegions); i++) begin
            match[i] = pma_match(entries[i], pma_addr_t'(req_addr_i));
        end
    end

    pma_prio_enc #(
        .N        (NrRegions),
        .IdxWidth (4)
    ) u_prio (
        .req_i (match),
        .hit_o (enc_hit),
        .idx_o (enc_idx)
    );

    always_comb begin
        look_attr = DefaultAttr;
        for (int i = 0; i < int'(NrRegions); i++) begin
            if (enc_hit && enc_idx == 4'(i)) begin
                look_attr = entries[i].attr;
            end
        end
    end

    assign req_ready_o = !resp_valid_o || resp_ready_i;

    // Table is sampled before any same-edge config write lands.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_idx_o   <= '0;
            resp_attr_q  <= '0;
        end else if (req_ready_o) begin
            resp_valid_o <= req_valid_i;
            if (req_valid_i) begin
                resp_hit_o  <= enc_hit;
                resp_idx_o  <= enc_hit ? enc_idx : 4'd0;
                resp_attr_q <= look_attr;
            end
        end
    end

    assign resp_attr_o = resp_attr_q;

endmodule

// File: tb/tb_pma_region_unit.sv
// Directed bench for pma_region_unit: reset table, priority, lock,
// invalid access, backpressure, top-of-space and write/lookup collision.
module tb_pma_region_unit;
    import pma_pkg::*;

    localparam logic [7:0][63:0] RB = 512'h8000_0000;
    localparam logic [7:0][63:0] RL = 512'h4000_0000;
    localparam pma_attr_t [7:0]  RA = 64'h09;
    localparam pma_attr_t        DA = pma_attr_t'(8'h02);

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cfg_we_i;
    logic        cfg_re_i;
    logic [3:0]  cfg_idx_i;
    logic [1:0]  cfg_sel_i;
    logic [63:0] cfg_wdata_i;
    logic [63:0] cfg_rdata_o;
    logic        cfg_err_o;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic        resp_hit_o;
    logic [3:0]  resp_idx_o;
    logic [7:0]  resp_attr_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pma_region_unit #(
        .NrRegions   (8),
        .AddrWidth   (64),
        .RstBase     (RB),
        .RstLength   (RL),
        .RstAttr     (RA),
        .DefaultAttr (DA)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cfg_we_i     (cfg_we_i),
        .cfg_re_i     (cfg_re_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_sel_i    (cfg_sel_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .cfg_err_o    (cfg_err_o),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_hit_o   (resp_hit_o),
        .resp_idx_o   (resp_idx_o),
        .resp_attr_o  (resp_attr_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [1:0] sel,
                             input logic [63:0] data);
        cfg_we_i    = 1'b1;
        cfg_idx_i   = idx;
        cfg_sel_i   = sel;
        cfg_wdata_i = data;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic cfg_read(input logic [3:0] idx, input logic [1:0] sel);
        cfg_re_i  = 1'b1;
        cfg_idx_i = idx;
        cfg_sel_i = sel;
        tick();
        cfg_re_i = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] addr);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic hit,
                            input logic [3:0] idx, input logic [7:0] attr);
        check({tag, ".valid"}, resp_valid_o, 1'b1);
        check({tag, ".hit"}, resp_hit_o, hit);
        check({tag, ".idx"}, resp_idx_o, idx);
        check({tag, ".attr"}, resp_attr_o, attr);
    endtask

    initial begin
        rst_ni       = 1'b0;
        cfg_we_i     = 1'b0;
        cfg_re_i     = 1'b0;
        cfg_idx_i    = '0;
        cfg_sel_i    = '0;
        cfg_wdata_i  = '0;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        resp_ready_i = 1'b1;
        tick();
        tick();
        check("rst.valid", resp_valid_o, 1'b0);
        check("rst.hit", resp_hit_o, 1'b0);
        check("rst.idx", resp_idx_o, 4'd0);
        check("rst.attr", resp_attr_o, 8'h00);
        check("rst.rdata", cfg_rdata_o, 64'h0);
        check("rst.err", cfg_err_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Reset-loaded region 0: [0x8000_0000, 0xC000_0000)
        lookup(64'h8000_0000);
        chk_resp("rst_hit", 1'b1, 4'd0, 8'h09);
        tick();
        check("idle.valid", resp_valid_o, 1'b0);
        lookup(64'hBFFF_FFFF);
        chk_resp("rst_last", 1'b1, 4'd0, 8'h09);
        lookup(64'hC000_0000);
        chk_resp("rst_end", 1'b0, 4'd0, 8'h02);

        // Overlapping regions 1 and 3; reserved attr bits dropped
        cfg_write(4'd1, SEL_BASE, 64'h1000);
        check("r1b.err", cfg_err_o, 1'b0);
        cfg_write(4'd1, SEL_LEN, 64'h1000);
        cfg_write(4'd1, SEL_ATTR, 64'h75);
        check("r1a.err", cfg_err_o, 1'b0);
        cfg_write(4'd3, SEL_BASE, 64'h1800);
        cfg_write(4'd3, SEL_LEN, 64'h100);
        cfg_write(4'd3, SEL_ATTR, 64'h03);
        cfg_read(4'd1, SEL_ATTR);
        check("r1a.rd", cfg_rdata_o, 64'h05);
        check("r1a.rderr", cfg_err_o, 1'b0);
        lookup(64'h1880);
        chk_resp("overlap", 1'b1, 4'd1, 8'h05);

        // Lock region 2
        cfg_write(4'd2, SEL_ATTR, 64'h81);
        check("lock.err", cfg_err_o, 1'b0);
        cfg_write(4'd2, SEL_BASE, 64'h2000);
        check("lockb.err", cfg_err_o, 1'b1);
        cfg_read(4'd2, SEL_BASE);
        check("lockb.rd", cfg_rdata_o, 64'h0);
        check("lockb.rderr", cfg_err_o, 1'b0);
        cfg_write(4'd2, SEL_ATTR, 64'h01);
        check("locka.err", cfg_err_o, 1'b1);
        cfg_read(4'd2, SEL_ATTR);
        check("locka.rd", cfg_rdata_o, 64'h81);

        // Invalid index / select
        cfg_write(4'd8, SEL_BASE, 64'h1234);
        check("badidx.err", cfg_err_o, 1'b1);
        cfg_read(4'd0, SEL_BASE);
        check("badidx.r0", cfg_rdata_o, 64'h8000_0000);
        cfg_read(4'd0, 2'd3);
        check("sel3.rd", cfg_rdata_o, 64'h0);
        check("sel3.err", cfg_err_o, 1'b1);
        tick();
        check("err.pulse", cfg_err_o, 1'b0);

        // Read and write together: write wins, rdata holds
        cfg_read(4'd1, SEL_LEN);
        check("r1l.rd", cfg_rdata_o, 64'h1000);
        cfg_re_i = 1'b1;
        cfg_write(4'd4, SEL_BASE, 64'h5000);
        cfg_re_i = 1'b0;
        check("rw.hold", cfg_rdata_o, 64'h1000);
        check("rw.err", cfg_err_o, 1'b0);
        cfg_read(4'd4, SEL_BASE);
        check("rw.rd", cfg_rdata_o, 64'h5000);

        // Backpressure: A = 0x1880 (hit r1), B = 0xC000_0000 (miss)
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b1;
        req_addr_i   = 64'h1880;
        tick();
        req_addr_i = 64'hC000_0000;
        for (int c = 0; c < 3; c++) begin
            chk_resp("bp.A", 1'b1, 4'd1, 8'h05);
            check("bp.ready", req_ready_o, 1'b0);
            tick();
        end
        resp_ready_i = 1'b1;
        #1;
        check("bp.rel", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0;
        chk_resp("bp.B", 1'b0, 4'd0, 8'h02);
        tick();
        check("bp.drain", resp_valid_o, 1'b0);

        // Region reaching the top of the address space
        cfg_write(4'd5, SEL_BASE, 64'hFFFF_FFFF_FFFF_F000);
        cfg_write(4'd5, SEL_LEN, 64'h1000);
        cfg_write(4'd5, SEL_ATTR, 64'h01);
        lookup(64'hFFFF_FFFF_FFFF_FFFF);
        chk_resp("top", 1'b1, 4'd5, 8'h01);
        lookup(64'hFFFF_FFFF_FFFF_EFFF);
        chk_resp("below", 1'b0, 4'd0, 8'h02);

        // Same-edge write of length=0 and lookup: old table seen
        req_valid_i = 1'b1;
        req_addr_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        cfg_write(4'd5, SEL_LEN, 64'h0);
        req_valid_i = 1'b0;
        chk_resp("coll.old", 1'b1, 4'd5, 8'h01);
        lookup(64'hFFFF_FFFF_FFFF_FFFF);
        chk_resp("coll.new", 1'b0, 4'd0, 8'h02);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
